// File: rtl/dti_apb_master_bridge.sv
// Single-outstanding valid/ready to APB3 master bridge with
// address-window decode error and PREADY timeout abort.
`ifndef CFG_APB_ADDR_WIDTH
`define CFG_APB_ADDR_WIDTH 32
`endif
`ifndef CFG_APB_DATA_WIDTH
`define CFG_APB_DATA_WIDTH 32
`endif

module dti_apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = `CFG_APB_ADDR_WIDTH,
  parameter int unsigned APB_DATA_WIDTH = `CFG_APB_DATA_WIDTH,
  parameter logic [31:0] APB_BASE_ADDR  = 32'h4000_0000,
  parameter logic [31:0] APB_WIN_SIZE   = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      apb_pclk,
  input  logic                      apb_preset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      timeout_o,
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic                      apb_pwrite,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata,
  input  logic                      apb_pready,
  input  logic                      apb_pslverr
);

  localparam int WW =
    (APB_ADDR_WIDTH > 32 ? APB_ADDR_WIDTH : 32) + 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_e;

  state_e                    state_q;
  logic [CW-1:0]             cnt_q;
  logic                      req_ready_q;
  logic                      rsp_valid_q;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
  logic                      rsp_err_q;
  logic                      timeout_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      pwrite_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;

  logic [WW-1:0] addr_x;
  logic [WW-1:0] lo_x;
  logic [WW-1:0] hi_x;
  logic          win_hit;
  logic          tmo_hit;

  // Widened compare so BASE+SIZE never wraps
  assign addr_x  = WW'(req_addr);
  assign lo_x    = WW'(APB_BASE_ADDR);
  assign hi_x    = WW'(APB_BASE_ADDR) + WW'(APB_WIN_SIZE);
  assign win_hit = (addr_x >= lo_x) && (addr_x < hi_x);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge apb_pclk) begin
    if (apb_preset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            if (win_hit) begin
              state_q  <= SETUP;
              psel_q   <= 1'b1;
              pwrite_q <= req_write;
              paddr_q  <= req_addr;
              pwdata_q <= req_wdata;
              cnt_q    <= '0;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (apb_pready) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= apb_pslverr;
            rsp_rdata_q <= pwrite_q ? '0 : apb_prdata;
          end else if (tmo_hit) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            timeout_q   <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign timeout_o   = timeout_q;
  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwrite  = pwrite_q;
  assign apb_paddr   = paddr_q;
  assign apb_pwdata  = pwdata_q;

endmodule

// File: tb/tb_dti_apb_master_bridge.sv
// Directed plus randomized bench for dti_apb_master_bridge,
// checked against a transaction-level expectation model.
module tb_dti_apb_master_bridge;

  localparam longint BASE = 64'h4000_0000;
  localparam longint SIZE = 64'h0001_0000;
  localparam int     TMO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, timeout_o;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dti_apb_master_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .APB_BASE_ADDR (32'h4000_0000),
    .APB_WIN_SIZE  (32'h0001_0000),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .apb_pclk   (clk),
    .apb_preset (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .timeout_o  (timeout_o),
    .apb_psel   (psel),
    .apb_penable(penable),
    .apb_pwrite (pwrite),
    .apb_paddr  (paddr),
    .apb_pwdata (pwdata),
    .apb_prdata (prdata),
    .apb_pready (pready),
    .apb_pslverr(pslverr)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    longint x;
    x = longint'(a);
    return (x >= BASE) && (x < BASE + SIZE);
  endfunction

  // Slave inserts wt wait states; bp = cycles of rsp_ready low
  task automatic run_txn(input string nm, input bit wr,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [31:0] prd,
                         input int wt, input bit slverr,
                         input int bp);
    bit hit, tmo, e_err, seen, stab_bad, rr_bad, hold_bad;
    int acc, e_psel, e_lat, n_psel, n_pen, n_tmo, lat, idx;
    logic [31:0] e_rd, rd0;
    logic        er0;
    hit    = in_win(addr);
    tmo    = hit && (wt >= TMO);
    acc    = !hit ? 0 : (tmo ? TMO : wt + 1);
    e_psel = hit ? acc + 1 : 0;
    e_lat  = hit ? acc + 2 : 1;
    e_err  = !hit || tmo || slverr;
    e_rd   = (hit && !tmo && !wr) ? prd : 32'h0;
    n_psel = 0; n_pen = 0; n_tmo = 0; lat = 0; idx = 0;
    seen = 0; stab_bad = 0; rr_bad = 0; hold_bad = 0;
    rd0 = '0; er0 = 1'b0;
    @(negedge clk);
    check({nm, ".req_ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = $urandom;
    for (int k = 1; k <= 60 && !seen; k++) begin
      if (psel) begin
        n_psel++;
        if (paddr !== addr || pwrite !== wr) stab_bad = 1;
        if (wr && pwdata !== wdata) stab_bad = 1;
      end
      if (penable) n_pen++;
      if (penable && !psel) stab_bad = 1;
      if (timeout_o) n_tmo++;
      if (req_ready) rr_bad = 1;
      if (rsp_valid) begin
        seen = 1; lat = k; rd0 = rsp_rdata; er0 = rsp_err;
      end
      if (!seen && penable && idx == wt) begin
        pready = 1'b1; pslverr = slverr; prdata = prd;
      end else begin
        pready = 1'b0; pslverr = $urandom; prdata = $urandom;
      end
      if (penable) idx++;
      if (!seen) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    pready = 1'b0;
    check({nm, ".rsp_seen"},   64'(seen), 64'd1);
    check({nm, ".latency"},    64'(lat), 64'(e_lat));
    check({nm, ".psel_cyc"},   64'(n_psel), 64'(e_psel));
    check({nm, ".pen_cyc"},    64'(n_pen), 64'(acc));
    check({nm, ".apb_stable"}, 64'(stab_bad), 64'd0);
    check({nm, ".rr_low"},     64'(rr_bad), 64'd0);
    check({nm, ".rdata"},      64'(rd0), 64'(e_rd));
    check({nm, ".err"},        64'(er0), 64'(e_err));
    check({nm, ".timeout"},    64'(n_tmo), 64'(tmo));
    rsp_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 ||
          rsp_err !== er0 || req_ready !== 1'b0 ||
          psel !== 1'b0 || timeout_o !== 1'b0)
        hold_bad = 1;
    end
    check({nm, ".rsp_hold"}, 64'(hold_bad), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, ".rsp_drop"}, 64'(rsp_valid), 64'd0);
    check({nm, ".rr_back"},  64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; prdata = 0; pready = 0; pslverr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.req_ready", 64'(req_ready), 64'd1);
    check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst.psel",      64'(psel), 64'd0);
    check("rst.penable",   64'(penable), 64'd0);
    check("rst.paddr",     64'(paddr), 64'd0);
    check("rst.rdata",     64'(rsp_rdata), 64'd0);
    check("rst.err",       64'(rsp_err), 64'd0);
    check("rst.timeout",   64'(timeout_o), 64'd0);
    rst = 1'b0;

    run_txn("t1", 0, 32'h4000_0010, 32'h0, 32'hA5A5_0001, 0, 0, 0);
    run_txn("t2", 1, 32'h4000_0020, 32'hDEAD_BEEF, 32'h1234_5678,
            3, 0, 0);
    run_txn("t3", 0, 32'h5000_0000, 32'h0, 32'h1111_1111, 0, 0, 0);
    run_txn("t4", 0, 32'h4000_0100, 32'h0, 32'h2222_2222,
            1000, 0, 1);
    run_txn("t4n", 0, 32'h4000_0104, 32'h0, 32'h3333_3333,
            2, 0, 0);
    run_txn("t5", 0, 32'h4000_0200, 32'h0, 32'h4444_4444,
            1, 1, 4);
    run_txn("tmo_edge15", 0, 32'h4000_0300, 32'h0, 32'h5555_AAAA,
            15, 0, 0);
    run_txn("tmo_edge16", 1, 32'h4000_0304, 32'h6, 32'h0,
            16, 0, 0);
    run_txn("win_lo", 0, 32'h4000_0000, 32'h0, 32'h0BAD_F00D,
            0, 0, 0);
    run_txn("win_hi", 0, 32'h4000_FFFF, 32'h0, 32'hC0DE_0001,
            0, 0, 0);
    run_txn("win_end", 0, 32'h4001_0000, 32'h0, 32'h7, 0, 0, 0);
    run_txn("win_below", 1, 32'h3FFF_FFFF, 32'h9, 32'h7, 0, 0, 0);
    run_txn("win_max", 0, 32'hFFFF_FFFF, 32'h0, 32'h7, 0, 0, 0);

    // Reset while waiting in ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0040;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t6.pre_penable", 64'(penable), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t6.psel",      64'(psel), 64'd0);
    check("t6.penable",   64'(penable), 64'd0);
    check("t6.rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6.req_ready", 64'(req_ready), 64'd1);
    check("t6.timeout",   64'(timeout_o), 64'd0);
    run_txn("t6n", 1, 32'h4000_0044, 32'hFACE_CAFE, 32'h0,
            0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(9);
      if (sel < 7)
        a = 32'h4000_0000 + ($urandom % 32'h0001_0000);
      else if (sel == 7)
        a = 32'h4001_0000 + $urandom_range(4096);
      else if (sel == 8)
        a = 32'h3FFF_FFFF - $urandom_range(4096);
      else
        a = $urandom;
      run_txn($sformatf("rnd%0d", n), 1'($urandom), a, $urandom,
              $urandom, $urandom_range(20), 1'($urandom),
              $urandom_range(5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
